// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and helpers for the instruction fetch front end.
//   fq_entry_t     : one fetch-queue entry, {pc, instr}
//   fetch_state_t  : fetch controller state (FETCH / HALT)
//   INSTR_BYTES    : size of one instruction word in bytes
//   addr_in_range(): true when a full instruction word at addr lies inside
//                    a ROM of mem_size bytes
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned INSTR_BYTES = 4;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

   typedef enum logic {
      FETCH = 1'b0,
      HALT  = 1'b1
   } fetch_state_t;

   // The last byte of the word must still be inside the ROM.
   function automatic logic addr_in_range(input logic [63:0] addr,
                                          input logic [63:0] mem_size);
      return (addr + 64'(INSTR_BYTES - 1)) < mem_size;
   endfunction

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular FIFO of fq_entry_t between the fetch PC logic and decode.
// Ports:
//   clk_i       : clock, all state updates on posedge
//   reset_n_i   : synchronous active-low reset (pointers and count only)
//   flush_i     : synchronous flush, wins over enqueue and dequeue
//   enq_i       : request to write enq_data_i at the tail
//   enq_data_i  : entry to write
//   deq_i       : consumer takes the head this cycle
//   deq_data_o  : head entry (zero while empty)
//   full_o      : count == DEPTH
//   empty_o     : count == 0
//   count_o     : occupancy
// An enqueue into a full queue is accepted when a dequeue fires in the same
// cycle.
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             flush_i,
   input  logic             enq_i,
   input  fq_entry_t        enq_data_i,
   input  logic             deq_i,
   output fq_entry_t        deq_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   fq_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             enq_fire;
   logic             deq_fire;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   assign deq_fire = deq_i & ~flush_i & ~empty_o;
   assign enq_fire = enq_i & ~flush_i & (~full_o | deq_fire);

   // Gated so the head never shows stale or uninitialised storage.
   assign deq_data_o = empty_o ? '0 : mem_q[head_q];

   // DEPTH is a power of two, so pointer increments wrap naturally.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (deq_fire) head_d = head_q + PTR_W'(1);
         if (enq_fire) tail_d = tail_q + PTR_W'(1);
         case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage carries data only; validity comes from count.
   always_ff @(posedge clk_i) begin
      if (enq_fire) mem_q[tail_q] <= enq_data_i;
   end

endmodule : fetch_queue

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the fetch PC, drives the combinational instruction ROM and pushes
// {pc, instr} into a fetch queue read by decode.
// Ports:
//   clk, reset_n             : clock and synchronous active-low reset
//   imem_addr / imem_instr   : ROM byte address (== PC) and returned word
//   redirect_valid/_pc       : branch/exception redirect; flushes the queue
//   deq_valid/_ready         : decode handshake on the queue head
//   deq_instr / deq_pc       : queue head contents
//   halted                   : fetch stopped because the PC left the ROM
//   fq_count                 : queue occupancy
// Fetch stops (HALT) once the PC no longer addresses a full word inside the
// ROM, since the ROM returns X there; only a redirect restarts it.
// -----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 1024,
   parameter int unsigned FQ_DEPTH = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   output logic [63:0]                    imem_addr,
   input  logic [31:0]                    imem_instr,
   input  logic                           redirect_valid,
   input  logic [63:0]                    redirect_pc,
   output logic                           deq_valid,
   input  logic                           deq_ready,
   output logic [31:0]                    deq_instr,
   output logic [63:0]                    deq_pc,
   output logic                           halted,
   output logic [$clog2(FQ_DEPTH+1)-1:0]  fq_count
);

   localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

   fetch_state_t state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic         in_range;
   logic         enq_ok;
   logic         enq;
   logic         flush;
   logic         deq_req;
   logic         q_full;
   logic         q_empty;
   fq_entry_t    enq_entry;
   fq_entry_t    head_entry;

   assign imem_addr = pc_q;
   assign in_range  = addr_in_range(pc_q, 64'(MEM_SIZE));
   assign halted    = (state_q == HALT);

   // A full queue still accepts a new word when the head leaves this cycle.
   assign enq_ok  = ~q_full | (deq_ready & ~q_empty);
   // Redirect kills the head, so a simultaneous ready is not a dequeue.
   assign deq_req = deq_ready & ~redirect_valid;

   assign enq_entry.pc    = pc_q;
   assign enq_entry.instr = imem_instr;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      enq     = 1'b0;
      flush   = 1'b0;
      if (redirect_valid) begin
         flush   = 1'b1;
         pc_d    = redirect_pc & ~64'(INSTR_BYTES - 1);
         state_d = addr_in_range(pc_d, 64'(MEM_SIZE)) ? FETCH : HALT;
      end else begin
         case (state_q)
            FETCH: begin
               if (!in_range) begin
                  state_d = HALT;
               end else if (enq_ok) begin
                  enq  = 1'b1;
                  pc_d = pc_q + 64'(INSTR_BYTES);
               end
            end
            HALT: begin
               state_d = HALT;
            end
            default: begin
               state_d = HALT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH),
      .CNT_W (CNT_W)
   ) u_fetch_queue (
      .clk_i      (clk),
      .reset_n_i  (reset_n),
      .flush_i    (flush),
      .enq_i      (enq),
      .enq_data_i (enq_entry),
      .deq_i      (deq_req),
      .deq_data_o (head_entry),
      .full_o     (q_full),
      .empty_o    (q_empty),
      .count_o    (fq_count)
   );

   assign deq_valid = ~q_empty;
   assign deq_pc    = head_entry.pc;
   assign deq_instr = head_entry.instr;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   localparam int unsigned MEM_SIZE = 1024;
   localparam int unsigned FQ_DEPTH = 4;
   localparam logic [63:0] RESET_PC = 64'h0;
   localparam logic [31:0] OOR_WORD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        deq_valid;
   logic        deq_ready = 1'b0;
   logic [31:0] deq_instr;
   logic [63:0] deq_pc;
   logic        halted;
   logic [2:0]  fq_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] rom [MEM_SIZE/4];

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   // Reference model state
   ent_t        m_q[$];
   logic [63:0] m_pc = RESET_PC;
   bit          m_halt = 1'b0;
   bit          m_just_reset = 1'b1;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [63:0] a);
      if (a + 64'd3 < 64'(MEM_SIZE)) return rom[a[9:2]];
      return OOR_WORD;
   endfunction

   assign imem_instr = rom_word(imem_addr);

   fetch_sequencer #(
      .MEM_SIZE (MEM_SIZE),
      .FQ_DEPTH (FQ_DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .deq_valid      (deq_valid),
      .deq_ready      (deq_ready),
      .deq_instr      (deq_instr),
      .deq_pc         (deq_pc),
      .halted         (halted),
      .fq_count       (fq_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One cycle: compare DUT against model at the negedge, apply inputs,
   // then advance the model to what the next posedge should produce.
   task automatic step(input logic rst_n, input logic red, input logic [63:0] rpc,
                       input logic rdy);
      bit do_deq, do_enq, rng;
      @(negedge clk);
      check("imem_addr", imem_addr, m_pc);
      check("halted", 64'(halted), 64'(m_halt));
      check("fq_count", 64'(fq_count), 64'(m_q.size()));
      check("deq_valid", 64'(deq_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("deq_pc", deq_pc, m_q[0].pc);
         check("deq_instr", 64'(deq_instr), 64'(m_q[0].instr));
      end else if (m_just_reset) begin
         check("deq_pc_rst", deq_pc, 64'h0);
         check("deq_instr_rst", 64'(deq_instr), 64'h0);
      end
      reset_n        = rst_n;
      redirect_valid = red;
      redirect_pc    = rpc;
      deq_ready      = rdy;
      m_just_reset   = 1'b0;
      if (!rst_n) begin
         m_q.delete();
         m_pc         = RESET_PC;
         m_halt       = 1'b0;
         m_just_reset = 1'b1;
      end else if (red) begin
         m_q.delete();
         m_pc   = {rpc[63:2], 2'b00};
         m_halt = !(m_pc + 64'd3 < 64'(MEM_SIZE));
      end else begin
         rng    = (m_pc + 64'd3 < 64'(MEM_SIZE));
         do_deq = rdy && (m_q.size() > 0);
         do_enq = !m_halt && rng && ((m_q.size() < FQ_DEPTH) || do_deq);
         if (!m_halt && !rng) m_halt = 1'b1;
         if (do_deq) void'(m_q.pop_front());
         if (do_enq) begin
            m_q.push_back('{pc: m_pc, instr: rom[m_pc[9:2]]});
            m_pc = m_pc + 64'd4;
         end
      end
   endtask

   function automatic logic [63:0] pick_target();
      case ($urandom_range(0, 5))
         0:       return 64'($urandom_range(0, MEM_SIZE/4 - 1)) << 2;
         1:       return 64'($urandom_range(0, MEM_SIZE - 1));
         2:       return 64'($urandom_range(MEM_SIZE - 12, MEM_SIZE - 1));
         3:       return 64'(MEM_SIZE);
         4:       return {$urandom(), $urandom()};
         default: return 64'h103;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < MEM_SIZE/4; i++) rom[i] = $urandom();

      // Reset, then streaming with decode always ready.
      step(1'b0, 1'b0, 64'h0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'h0, 1'b1);

      // Back-pressure fills the queue, then release.
      step(1'b0, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 64'h0, 1'b1);

      // Three queued entries, then unaligned redirect (ready ignored).
      step(1'b0, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h0, 1'b0);
      step(1'b1, 1'b1, 64'h103, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 64'h0, 1'b1);

      // Run off the end of the ROM, halt, drain.
      step(1'b1, 1'b1, 64'h3E0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 64'h0, 1'b1);

      // Restart from halt, then redirect out of range.
      step(1'b1, 1'b1, 64'h20, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'h0, 1'b1);
      step(1'b1, 1'b1, 64'h400, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 64'h0, 1'b1);

      // One-cycle reset with a full queue.
      step(1'b1, 1'b1, 64'h40, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'h0, 1'b0);
      step(1'b0, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h0, 1'b1);

      // Randomised segments with varying ready density.
      for (int seg = 0; seg < 80; seg++) begin
         int rdy_pct;
         rdy_pct = $urandom_range(0, 100);
         for (int c = 0; c < 40; c++) begin
            logic r, red, rdy;
            r   = ($urandom_range(0, 199) != 0);
            red = ($urandom_range(0, 29) == 0);
            rdy = ($urandom_range(1, 100) <= rdy_pct);
            step(r, red, pick_target(), rdy);
         end
      end

      step(1'b1, 1'b0, 64'h0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_sequencer

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller for the combinational instruction ROM (64-bit byte address in, 32-bit word out, `INSTRUCT_MEM_SIZE bytes).
- Owns the fetch PC and drives the ROM address every cycle.
- Captures {pc, instruction} into a small circular fetch queue that feeds decode via a valid/ready handshake.
- Handles branch redirects (queue flush) and halts fetch when the PC leaves ROM bounds, since the ROM returns X there.

Parameters:
- MEM_SIZE, 1024: ROM size in bytes; power of two, must match `INSTRUCT_MEM_SIZE.
- FQ_DEPTH, 4: fetch-queue entries; power of two, >= 2.
- RESET_PC, 64'h0: PC loaded on reset.

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- imem_addr  out  64  ROM byte address; always equals the current PC register.
- imem_instr  in  32  ROM read data, combinational from imem_addr.
- redirect_valid  in  1  branch/exception redirect from the ROB/branch unit.
- redirect_pc  in  64  redirect target.
- deq_valid  out  1  queue head valid.
- deq_ready  in  1  decode accepts the head this cycle.
- deq_instr  out  32  head instruction.
- deq_pc  out  64  head PC.
- halted  out  1  fetch stopped because the PC is out of range.
- fq_count  out  $clog2(FQ_DEPTH+1)  queue occupancy.

Behaviour:
- Reset (reset_n=0 at posedge):
  - pc<=RESET_PC; head/tail/count<=0; state<=FETCH.
  - Outputs: deq_valid=0, halted=0, fq_count=0. deq_instr/deq_pc are don't-care but must not be X in simulation; clear them to 0.
  - Reset mid-operation discards all queue contents.
- FSM states:
  - FETCH: normal fetching.
  - HALT: fetch stopped; halted=1.
- in_range = (pc + 3 < MEM_SIZE). Use 64-bit arithmetic; there is no wrap at 2^64 within the range of interest.
- deq fire = deq_valid & deq_ready. Enqueue is allowed when count<FQ_DEPTH, or when count==FQ_DEPTH and a deq fires the same cycle (full+deq+enq is legal).
- FETCH, no redirect, in_range, enqueue allowed:
  - Write {pc, imem_instr} at tail; tail<=tail+1 mod FQ_DEPTH; pc<=pc+4.
- FETCH, no redirect, enqueue not allowed: pc holds, no write (stall).
- FETCH, no redirect, !in_range: state<=HALT, no write, pc holds. Queued entries still drain normally.
- HALT, no redirect: no enqueue. Deq continues until the queue is empty.
- Redirect (any state) has highest priority over fetch and dequeue:
  - Queue flush: head<=0, tail<=0, count<=0, so deq_valid=0 next cycle.
  - pc <= {redirect_pc[63:2], 2'b00}.
  - No enqueue that cycle. A deq_ready asserted that cycle is ignored; the consumer must treat the flush as killing the head.
  - Next state = FETCH if the new pc is in range, else HALT.
  - First enqueue from the new pc happens the cycle after the redirect.
- Count update: count <= count + enq - deq (each 0/1); never exceeds FQ_DEPTH and never underflows.
- Dequeue side:
  - deq_valid = (count != 0).
  - deq_instr/deq_pc read combinationally from the head entry.
  - On fire, head<=head+1 mod FQ_DEPTH.
- Latency: ROM address to queue entry is 1 cycle. An empty queue with ready decode shows deq_valid the cycle after the enqueue. Sustained throughput is 1 instr/cycle.
- imem_addr is always 4-byte aligned. An X on imem_instr is enqueued only if in_range is violated, which the FSM forbids.

Decomposition:
- Shared package fetch_pkg:
  - typedef fq_entry_t = struct {logic [63:0] pc; logic [31:0] instr;}
  - enum fetch_state_t {FETCH, HALT}
  - localparam INSTR_BYTES = 4.
- One sub-module: fetch_queue, a parameterised circular FIFO of fq_entry_t with a synchronous flush input and full/empty/count outputs. fetch_sequencer holds the PC, FSM and range check.

Test Plan:
- Reset then deq_ready=1 held, ROM words 0..3 known → deq_pc 0,4,8,12 on consecutive cycles starting cycle 2 after reset release; deq_instr matches mem[0..3].
- deq_ready=0 for 10 cycles → fq_count saturates at 4 with deq_pc=0, imem_addr stalls at 16; deq_ready=1 → dequeue and enqueue in the same cycle, count stays 4, pc advances 16,20,…
- Redirect to 64'h103 while the queue holds 3 entries → next cycle deq_valid=0, fq_count=0, imem_addr=0x100; following cycle deq_pc=0x100.
- Sequential fetch runs to pc=1020 → entry 1020 enqueued, then halted=1 at pc=1024 with no further enqueues; the queue drains to empty.
- While halted, redirect to 0x20 → halted=0, fetch resumes at 0x20. Redirect to 0x400 instead → stays halted, queue empty.
- reset_n=0 asserted for one cycle mid-stream with a full queue → next cycle fq_count=0, deq_valid=0, imem_addr=RESET_PC.
